// File: rtl/debounce_botao_pkg.sv
// Shared definitions for the push-button conditioning path: FSM state codes,
// 50 MHz timing defaults and the registered output bundle.
package debounce_botao_pkg;

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_WAIT_PRESS   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

  // 20 ms and 2 s at 50 MHz; also used by the stopwatch clock divider.
  localparam int DEBOUNCE_20MS_50MHZ = 1_000_000;
  localparam int LONG_2S_50MHZ       = 100_000_000;

  typedef struct packed {
    logic key_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press;
  } botao_out_t;

endpackage

// File: rtl/debounce_botao_sincronizador_2ff.sv
// Two-flop synchroniser for asynchronous pins; clears to 0 on reset.
module sincronizador_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule

// File: rtl/debounce_botao.sv
// Debounces one push-button: synchronises the pin, accepts a change only after
// DEBOUNCE_CYCLES stable samples, and emits press/release/long-press strobes.
module debounce_botao
  import debounce_botao_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
  parameter int LONG_CYCLES     = LONG_2S_50MHZ
) (
  input  logic clock,
  input  logic reset,
  input  logic key_raw,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_CYCLES - 2);

  logic          w_p;
  logic          w_s2;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [HW-1:0] r_hold;
  botao_out_t    r_out;

  assign w_p = ACTIVE_LOW ? ~key_raw : key_raw;

  sincronizador_2ff #(
    .WIDTH(1)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (w_p),
    .q    (w_s2)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_RELEASED;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_out   <= '0;
    end else begin
      r_out.press_pulse   <= 1'b0;
      r_out.release_pulse <= 1'b0;
      r_out.long_press    <= 1'b0;
      case (r_state)
        ST_RELEASED: begin
          if (w_s2) begin
            r_state <= ST_WAIT_PRESS;
            r_cnt   <= '0;
          end
        end
        ST_WAIT_PRESS: begin
          if (!w_s2) begin
            r_state <= ST_RELEASED;
          end else if (r_cnt == CNT_LAST) begin
            r_state           <= ST_PRESSED;
            r_out.key_level   <= 1'b1;
            r_out.press_pulse <= 1'b1;
            r_hold            <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!w_s2) begin
            r_state <= ST_WAIT_RELEASE;
            r_cnt   <= '0;
          end else if (r_hold < HOLD_LAST) begin
            // Saturating at HOLD_LAST is what keeps long_press one-shot.
            r_hold <= r_hold + 1'b1;
            if (r_hold == HOLD_PRE) begin
              r_out.long_press <= 1'b1;
            end
          end
        end
        ST_WAIT_RELEASE: begin
          if (w_s2) begin
            r_state <= ST_PRESSED;
          end else if (r_cnt == CNT_LAST) begin
            r_state             <= ST_RELEASED;
            r_out.key_level     <= 1'b0;
            r_out.release_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_RELEASED;
      endcase
    end
  end

  assign key_level     = r_out.key_level;
  assign press_pulse   = r_out.press_pulse;
  assign release_pulse = r_out.release_pulse;
  assign long_press    = r_out.long_press;

endmodule
